prefetch_queue: RTL

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue: two-entry instruction prefetch buffer with a serial 2-bit
// read channel, immediate (imm16) capture and PC redirect handling.
// Optional build macro: PREFETCH_CONT_EN -- when defined, a completed fetch
// chains straight into the next request without an IDLE cycle.
module prefetch_queue (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_valid,
    output logic [15:0] inst,
    input  logic        inst_done,
    input  logic        load_imm16,
    output logic        imm16_loaded,
    output logic [15:0] imm_full,
    output logic [1:0]  imm_data_in,
    input  logic        next_imm_data,
    input  logic        block_prefetch,
    output logic        prefetch_idle,
    input  logic        write_pc,
    input  logic [15:0] pc_in,
    output logic        fetch_req,
    output logic [15:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic        rx_data_valid,
    input  logic [1:0]  rx_pins
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_DISCARD} state_t;

    state_t      r_state;
    logic [15:0] r_e0, r_e1;
    logic        r_v0, r_v1;
    logic [15:0] r_asm;
    logic [2:0]  r_chunk;
    logic [15:0] r_pc;
    logic [15:0] r_imm, r_imm_full;
    logic        r_imm_loaded;
    logic        r_fetch_req;
    logic [15:0] r_fetch_addr;

    logic        w_last_chunk, w_push, w_pop;
    logic        w_imm_arm, w_take_e1, w_take_push;
    logic [15:0] w_word, w_pc_inc;
    logic [15:0] w_e0_n, w_e1_n;
    logic        w_v0_n, w_v1_n;

    assign w_last_chunk = rx_data_valid && (r_chunk == 3'd7);
    // A redirect in the same cycle as the final chunk drops the word.
    assign w_push       = (r_state == S_RECV) && w_last_chunk && !write_pc;
    assign w_word       = {rx_pins, r_asm[13:0]};
    assign w_pop        = inst_done && r_v0;
    assign w_pc_inc     = r_pc + 16'd2;

    // Immediate capture: take entry1 if present, otherwise the next pushed word.
    assign w_imm_arm    = load_imm16 && r_v0 && !r_imm_loaded && !w_pop && !write_pc;
    assign w_take_e1    = w_imm_arm && r_v1;
    assign w_take_push  = w_imm_arm && !r_v1 && w_push;

    // Next FIFO contents: flush beats everything, then removal, then push.
    always_comb begin
        w_v0_n = r_v0;
        w_v1_n = r_v1;
        w_e0_n = r_e0;
        w_e1_n = r_e1;
        if (write_pc) begin
            w_v0_n = 1'b0;
            w_v1_n = 1'b0;
        end else begin
            if (w_take_e1)
                w_v1_n = 1'b0;
            if (w_pop) begin
                w_e0_n = r_e1;
                w_v0_n = r_v1;
                w_v1_n = 1'b0;
            end
            if (w_push && !w_take_push) begin
                if (!w_v0_n) begin
                    w_e0_n = w_word;
                    w_v0_n = 1'b1;
                end else begin
                    w_e1_n = w_word;
                    w_v1_n = 1'b1;
                end
            end
        end
    end

`ifdef PREFETCH_CONT_EN
    logic w_fetch_ok_n;
    assign w_fetch_ok_n = !block_prefetch && !(w_v0_n && w_v1_n);
`endif

    // FIFO, PC, immediate register and fetch FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_e0         <= '0;
            r_e1         <= '0;
            r_v0         <= 1'b0;
            r_v1         <= 1'b0;
            r_asm        <= '0;
            r_chunk      <= '0;
            r_pc         <= '0;
            r_imm        <= '0;
            r_imm_full   <= '0;
            r_imm_loaded <= 1'b0;
            r_fetch_req  <= 1'b0;
            r_fetch_addr <= '0;
        end else begin
            r_e0 <= w_e0_n;
            r_e1 <= w_e1_n;
            r_v0 <= w_v0_n;
            r_v1 <= w_v1_n;

            if (write_pc)
                r_pc <= pc_in;
            else if (w_push)
                r_pc <= w_pc_inc;

            if (w_take_e1) begin
                r_imm      <= r_e1;
                r_imm_full <= r_e1;
            end else if (w_take_push) begin
                r_imm      <= w_word;
                r_imm_full <= w_word;
            end else if (next_imm_data) begin
                r_imm <= {r_imm[1:0], r_imm[15:2]};
            end

            if (write_pc)
                r_imm_loaded <= 1'b0;
            else if (w_take_e1 || w_take_push)
                r_imm_loaded <= 1'b1;
            else if (inst_done)
                r_imm_loaded <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!write_pc && !block_prefetch && !(r_v0 && r_v1)) begin
                        r_state      <= S_REQ;
                        r_fetch_req  <= 1'b1;
                        r_fetch_addr <= r_pc;
                    end
                end
                S_REQ: begin
                    if (write_pc) begin
                        r_state     <= S_IDLE;
                        r_fetch_req <= 1'b0;
                    end else if (fetch_ack) begin
                        r_state     <= S_RECV;
                        r_fetch_req <= 1'b0;
                        r_chunk     <= '0;
                    end
                end
                S_RECV: begin
                    if (rx_data_valid) begin
                        r_asm[{r_chunk, 1'b0} +: 2] <= rx_pins;
                        r_chunk <= r_chunk + 3'd1;
                    end
                    if (write_pc) begin
                        r_state <= w_last_chunk ? S_IDLE : S_DISCARD;
                    end else if (w_last_chunk) begin
`ifdef PREFETCH_CONT_EN
                        if (w_fetch_ok_n) begin
                            r_state      <= S_REQ;
                            r_fetch_req  <= 1'b1;
                            r_fetch_addr <= w_pc_inc;
                        end else begin
                            r_state <= S_IDLE;
                        end
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
                S_DISCARD: begin
                    if (rx_data_valid)
                        r_chunk <= r_chunk + 3'd1;
                    if (w_last_chunk)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign inst_valid    = r_v0;
    assign inst          = r_e0;
    assign imm16_loaded  = r_imm_loaded;
    assign imm_full      = r_imm_full;
    assign imm_data_in   = r_imm[1:0];
    assign prefetch_idle = (r_state == S_IDLE);
    assign fetch_req     = r_fetch_req;
    assign fetch_addr    = r_fetch_addr;
endmodule
